// File: rtl/wasca_onchip_mem_initiator.sv
// Command-driven Avalon-MM FILL/CHECK initiator for the single-port on-chip RAM.
// Optional m_waitrequest handshake: define WASCA_MEMINIT_WAITREQ_EN.
module wasca_onchip_mem_initiator #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned LEN_W        = 11,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic              cmd_inc,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata
`ifdef WASCA_MEMINIT_WAITREQ_EN
   ,input  logic              m_waitrequest
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                init_q;
    logic                done_q, done_d;
    logic                op_q, op_d;
    logic                inc_q, inc_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         pat_q, pat_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic [LEN_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic [READ_LATENCY-1:0] pv_q, pv_d;
    logic [31:0]         pexp_q  [READ_LATENCY];
    logic [31:0]         pexp_d  [READ_LATENCY];
    logic [ADDR_W-1:0]   paddr_q [READ_LATENCY];
    logic [ADDR_W-1:0]   paddr_d [READ_LATENCY];

    logic stall;
    logic advance;
    logic tap_v;
    logic pend;

`ifdef WASCA_MEMINIT_WAITREQ_EN
    assign stall = cs_q & m_waitrequest;
`else
    assign stall = 1'b0;
`endif
    assign advance = cs_q & ~stall;
    assign tap_v   = pv_q[READ_LATENCY-1] & ~stall;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        op_d    = op_q;
        inc_d   = inc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        pat_d   = pat_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        pv_d    = pv_q;
        pexp_d  = pexp_q;
        paddr_d = paddr_q;
        pend    = 1'b0;

        // Reads still in flight other than the one being compared at the tap this cycle.
        for (int unsigned j = 0; j + 1 < READ_LATENCY; j++) begin
            pend = pend | pv_q[j];
        end

        if (!stall) begin
            pv_d[0]    = cs_q & ~wr_q;
            pexp_d[0]  = pat_q;
            paddr_d[0] = addr_q;
            for (int unsigned j = 1; j < READ_LATENCY; j++) begin
                pv_d[j]    = pv_q[j-1];
                pexp_d[j]  = pexp_q[j-1];
                paddr_d[j] = paddr_q[j-1];
            end
        end

        if (tap_v && (m_readdata != pexp_q[READ_LATENCY-1])) begin
            if (err_q == '0) begin
                ferr_d = paddr_q[READ_LATENCY-1];
            end
            if (err_q != '1) begin
                err_d = err_q + LEN_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && init_q) begin
                    op_d   = cmd_op;
                    inc_d  = cmd_inc;
                    len_d  = cmd_len;
                    idx_d  = '0;
                    addr_d = cmd_addr;
                    pat_d  = cmd_data;
                    err_d  = '0;
                    ferr_d = '0;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        cs_d    = 1'b1;
                        wr_d    = ~cmd_op;
                    end
                end
            end
            S_ISSUE: begin
                if (advance) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = op_q ? S_DRAIN : S_DONE;
                    end else begin
                        idx_d  = idx_q + LEN_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        pat_d  = inc_q ? pat_q + 32'd1 : pat_q;
                    end
                end
            end
            S_DRAIN: begin
                if (!pend) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= 1'b0;
            inc_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            pat_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            pv_q    <= '0;
            for (int unsigned j = 0; j < READ_LATENCY; j++) begin
                pexp_q[j]  <= '0;
                paddr_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            done_q  <= done_d;
            op_q    <= op_d;
            inc_q   <= inc_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pv_q    <= pv_d;
            pexp_q  <= pexp_d;
            paddr_q <= paddr_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE) & init_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign m_address      = addr_q;
    assign m_chipselect   = cs_q;
    assign m_write        = wr_q;
    assign m_writedata    = wr_q ? pat_q : '0;
    assign m_byteenable   = {4{cs_q}};
    assign m_clken        = 1'b1;

endmodule

// File: tb/tb_wasca_onchip_mem_initiator.sv
// Directed bench for wasca_onchip_mem_initiator with a behavioural 1-cycle-latency RAM.
module tb_wasca_onchip_mem_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic        cmd_inc;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [31:0] cmd_data;
    logic        busy;
    logic        done;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;
    logic [9:0]  m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic [31:0] m_readdata;

    int n_cmp = 0;
    int n_err = 0;

    wasca_onchip_mem_initiator #(
        .ADDR_W(10),
        .LEN_W(11),
        .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_inc(cmd_inc),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .busy(busy),
        .done(done),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .m_address(m_address),
        .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_clken(m_clken),
        .m_readdata(m_readdata)
`ifdef WASCA_MEMINIT_WAITREQ_EN
       ,.m_waitrequest(1'b0)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: registered read, one cycle latency; corrupt port lets the bench plant bad words.
    logic [31:0] mem [1024];
    logic        corrupt_en = 1'b0;
    logic [9:0]  corrupt_addr = '0;
    logic [31:0] corrupt_data = '0;

    always @(posedge clk) begin
        if (m_chipselect && m_write) mem[m_address] <= m_writedata;
        else if (m_chipselect) m_readdata <= mem[m_address];
        if (corrupt_en) mem[corrupt_addr] <= corrupt_data;
    end

    // Results of the most recent run_cmd
    logic [41:0] wlog [16];
    int nw, nr, first_cs, done_k, conflict;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic corrupt(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        corrupt_en = 1'b1; corrupt_addr = a; corrupt_data = d;
        @(negedge clk);
        corrupt_en = 1'b0;
    endtask

    task automatic run_cmd(input logic op, input logic inc, input logic [9:0] a,
                           input logic [10:0] len, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_inc = inc;
        cmd_addr = a; cmd_len = len; cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_inc = ~inc;
        cmd_addr = '1; cmd_len = '1; cmd_data = 32'hFFFF_FFFF;
        nw = 0; nr = 0; first_cs = -1; done_k = -1; conflict = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (m_chipselect) begin
                if (first_cs < 0) first_cs = k;
                if (m_write) begin
                    if (nw < 16) wlog[nw] = {m_address, m_writedata};
                    nw++;
                end else begin
                    nr++;
                end
            end
            if (busy && cmd_ready) conflict++;
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    logic seen_done;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_inc = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_data = '0;

        @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_outs_a", 64'({busy, done, err_count, first_err_addr, m_chipselect, m_write, m_byteenable}), 64'd0);
        check("rst_outs_b", 64'({m_address, m_writedata}), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Incrementing fill wrapping past the top of the address space
        run_cmd(1'b0, 1'b1, 10'h3FE, 11'd4, 32'h100);
        check("fill_nw", 64'(nw), 64'd4);
        check("fill_w0", 64'(wlog[0]), {22'd0, 10'h3FE, 32'h100});
        check("fill_w1", 64'(wlog[1]), {22'd0, 10'h3FF, 32'h101});
        check("fill_w2", 64'(wlog[2]), {22'd0, 10'h000, 32'h102});
        check("fill_w3", 64'(wlog[3]), {22'd0, 10'h001, 32'h103});
        check("fill_first_cs", 64'(first_cs), 64'd1);
        check("fill_done_k", 64'(done_k), 64'd6);
        check("fill_ready_busy", 64'(conflict), 64'd0);

        run_cmd(1'b1, 1'b1, 10'h3FE, 11'd4, 32'h100);
        check("chk_nr", 64'(nr), 64'd4);
        check("chk_done_k", 64'(done_k), 64'd7);
        check("chk_err", 64'(err_count), 64'd0);
        @(negedge clk);
        check("chk_busy_after", 64'(busy), 64'd0);

        corrupt(10'h000, 32'hDEAD);
        run_cmd(1'b1, 1'b1, 10'h3FE, 11'd4, 32'h100);
        check("bad1_err", 64'(err_count), 64'd1);
        check("bad1_first", 64'(first_err_addr), 64'h000);
        check("bad1_done_k", 64'(done_k), 64'd7);

        corrupt(10'h3FF, 32'hBEEF);
        run_cmd(1'b1, 1'b1, 10'h3FE, 11'd4, 32'h100);
        check("bad2_err", 64'(err_count), 64'd2);
        check("bad2_first", 64'(first_err_addr), 64'h3FF);

        // Zero-length commands: no bus traffic, counters cleared
        run_cmd(1'b1, 1'b1, 10'h3FE, 11'd0, 32'h100);
        check("len0c_cs", 64'(first_cs), 64'hFFFF_FFFF_FFFF_FFFF);
        check("len0c_done_k", 64'(done_k), 64'd2);
        check("len0c_err", 64'({err_count, first_err_addr}), 64'd0);
        run_cmd(1'b0, 1'b0, 10'h005, 11'd0, 32'h1234);
        check("len0f_cs", 64'(first_cs), 64'hFFFF_FFFF_FFFF_FFFF);
        check("len0f_done_k", 64'(done_k), 64'd2);

        // Constant pattern
        run_cmd(1'b0, 1'b0, 10'h010, 11'd3, 32'hA5A5_A5A5);
        check("const_w0", 64'(wlog[0]), {22'd0, 10'h010, 32'hA5A5_A5A5});
        check("const_w2", 64'(wlog[2]), {22'd0, 10'h012, 32'hA5A5_A5A5});
        check("const_done_k", 64'(done_k), 64'd5);
        run_cmd(1'b1, 1'b0, 10'h010, 11'd3, 32'hA5A5_A5A5);
        check("const_chk_err", 64'(err_count), 64'd0);
        check("const_chk_done_k", 64'(done_k), 64'd6);
        run_cmd(1'b1, 1'b1, 10'h010, 11'd3, 32'hA5A5_A5A5);
        check("inc_vs_const_err", 64'(err_count), 64'd2);
        check("inc_vs_const_first", 64'(first_err_addr), 64'h011);

        // Reset during write 2 of a len=8 fill
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_inc = 1'b1;
        cmd_addr = 10'h020; cmd_len = 11'd8; cmd_data = 32'h55;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_wr2", 64'({m_chipselect, m_address, m_writedata}), {21'd0, 1'b1, 10'h021, 32'h56});
        reset = 1'b1;
        #1;
        check("abort_outs_a", 64'({cmd_ready, busy, done, err_count, first_err_addr, m_chipselect, m_write, m_byteenable}), 64'd0);
        check("abort_outs_b", 64'({m_address, m_writedata}), 64'd0);
        seen_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (k == 0) check("abort_ready_after", 64'(cmd_ready), 64'd1);
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_idle", 64'({busy, m_chipselect}), 64'd0);

        // Single-word fill at the top address
        run_cmd(1'b0, 1'b1, 10'h3FF, 11'd1, 32'h7);
        check("len1_nw", 64'(nw), 64'd1);
        check("len1_w0", 64'(wlog[0]), {22'd0, 10'h3FF, 32'h7});
        check("len1_done_k", 64'(done_k), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
